serial_word_adder: RTL and testbench

//  Parametrised Mealy-style serial adder/subtractor: takes two WORD_W-bit operands via valid/ready,

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/serial_add_digit.sv | 23 ++
 rtl/serial_word_adder.sv | 133 +++++++++++++
 tb/tb_serial_word_adder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared FSM encoding and sizing helper for the serial word adder
package serial_add_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Digit index width; a single-digit word still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_add_digit.sv
// rtl/serial_add_digit.sv - combinational DIGIT_W-bit adder slice with carry into its MSB
module serial_add_digit #(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               ci,
    output logic [DIGIT_W-1:0] s,
    output logic               co,
    output logic               c_msb
);

    logic [DIGIT_W:0] full;

    always_comb begin
        full  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, ci};
        s     = full[DIGIT_W-1:0];
        co    = full[DIGIT_W];
        // Carry entering the top bit falls out of that bit's sum equation.
        c_msb = s[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b[DIGIT_W-1];
    end

endmodule

// File: rtl/serial_word_adder.sv
// rtl/serial_word_adder.sv - digit-serial add/subtract with valid/ready operand and result handshakes
import serial_add_pkg::*;

module serial_word_adder #(
    parameter int WORD_W  = 16,
    parameter int DIGIT_W = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  a,
    input  logic [WORD_W-1:0]  b,
    input  logic               cin,
    input  logic               sub,
    output logic               dig_valid,
    output logic [DIGIT_W-1:0] dig_sum,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WORD_W-1:0]  sum,
    output logic               cout,
    output logic               ovf
);

    localparam int N     = WORD_W / DIGIT_W;
    localparam int IDX_W = idx_width(N);

    generate
        if ((WORD_W < 1) || (DIGIT_W < 1) || ((WORD_W % DIGIT_W) != 0)) begin : g_bad_params
            $error("serial_word_adder: DIGIT_W must divide WORD_W");
        end
    endgenerate

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  a_q, a_d;
    logic [WORD_W-1:0]  b_q, b_d;
    logic [WORD_W-1:0]  sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [DIGIT_W-1:0] a_dig, b_dig, s_dig;
    logic               co_dig, cmsb_dig;
    logic               last_dig;

    always_comb begin
        a_dig    = a_q[idx_q * DIGIT_W +: DIGIT_W];
        b_dig    = b_q[idx_q * DIGIT_W +: DIGIT_W];
        last_dig = (idx_q == IDX_W'(N - 1));
    end

    serial_add_digit #(.DIGIT_W(DIGIT_W)) u_digit (
        .a     (a_dig),
        .b     (b_dig),
        .ci    (carry_q),
        .s     (s_dig),
        .co    (co_dig),
        .c_msb (cmsb_dig)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1 - cin, so the borrow-in inverts into the carry.
                    a_d     = a;
                    b_d     = b ^ {WORD_W{sub}};
                    carry_d = cin ^ sub;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                carry_d = co_dig;
                sum_d[idx_q * DIGIT_W +: DIGIT_W] = s_dig;
                idx_d   = idx_q + 1'b1;
                if (last_dig) begin
                    cout_d  = co_dig;
                    ovf_d   = cmsb_dig ^ co_dig;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        dig_valid = (state_q == ST_RUN);
        res_valid = (state_q == ST_DONE);
        dig_sum   = dig_valid ? s_dig : '0;
        sum       = sum_q;
        cout      = cout_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_serial_word_adder.sv
// tb/tb_serial_word_adder.sv - directed and random checks of three serial_word_adder digit widths
module tb_serial_word_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [7:0]      a, b;
    logic            cin, sub;
    logic [2:0]      in_valid, in_ready, res_ready, res_valid, dig_valid, cout_o, ovf_o;
    logic [2:0][7:0] sum_o;
    logic [0:0]      ds1;
    logic [3:0]      ds4;
    logic [7:0]      ds8;

    int errors = 0;
    int checks = 0;

    serial_word_adder #(.WORD_W(8), .DIGIT_W(1)) u_d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .dig_valid(dig_valid[0]), .dig_sum(ds1),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]), .sum(sum_o[0]),
        .cout(cout_o[0]), .ovf(ovf_o[0]));

    serial_word_adder #(.WORD_W(8), .DIGIT_W(4)) u_d4 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .dig_valid(dig_valid[1]), .dig_sum(ds4),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]), .sum(sum_o[1]),
        .cout(cout_o[1]), .ovf(ovf_o[1]));

    serial_word_adder #(.WORD_W(8), .DIGIT_W(8)) u_d8 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .cin(cin), .sub(sub), .dig_valid(dig_valid[2]), .dig_sum(ds8),
        .res_valid(res_valid[2]), .res_ready(res_ready[2]), .sum(sum_o[2]),
        .cout(cout_o[2]), .ovf(ovf_o[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {ovf, cout, sum} from integer arithmetic on the operands.
    function automatic logic [9:0] ref_model(input logic [7:0] oa, input logic [7:0] ob,
                                             input logic ocin, input logic osub);
        int ua, ub, sa, sb, r, sr;
        logic c, v;
        logic [7:0] s;
        ua = int'(oa);
        ub = int'(ob);
        sa = $signed(oa);
        sb = $signed(ob);
        if (!osub) begin
            r  = ua + ub + int'(ocin);
            sr = sa + sb + int'(ocin);
            c  = (r > 255);
        end else begin
            r  = ua - ub - int'(ocin);
            sr = sa - sb - int'(ocin);
            c  = (r >= 0);
        end
        s = r[7:0];
        v = (sr > 127) || (sr < -128);
        return {v, c, s};
    endfunction

    function automatic logic [7:0] get_dig(input int i);
        case (i)
            0:       return {7'd0, ds1};
            1:       return {4'd0, ds4};
            default: return ds8;
        endcase
    endfunction

    task automatic do_op(input int i, input logic [7:0] oa, input logic [7:0] ob,
                         input logic ocin, input logic osub, input int hold,
                         input bit rand_ready, input string tag);
        logic [9:0] e;
        logic [7:0] exp_dig;
        int n, d;
        e = ref_model(oa, ob, ocin, osub);
        n = (i == 0) ? 8 : (i == 1) ? 2 : 1;
        d = 8 / n;
        a = oa; b = ob; cin = ocin; sub = osub;
        in_valid[i] = 1'b1;
        check($sformatf("%s:in_ready_idle", tag), 32'(in_ready[i]), 1);
        tick();
        in_valid[i] = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        for (int k = 0; k < n; k++) begin
            exp_dig = 8'((int'(e[7:0]) >> (k * d)) & ((1 << d) - 1));
            check($sformatf("%s:dig_valid%0d", tag, k), 32'(dig_valid[i]), 1);
            check($sformatf("%s:dig_sum%0d", tag, k), 32'(get_dig(i)), 32'(exp_dig));
            check($sformatf("%s:res_valid_run%0d", tag, k), 32'(res_valid[i]), 0);
            check($sformatf("%s:in_ready_run%0d", tag, k), 32'(in_ready[i]), 0);
            if (rand_ready) res_ready[i] = 1'($urandom);
            tick();
        end
        res_ready[i] = 1'b0;
        check($sformatf("%s:latency", tag), 32'(res_valid[i]), 1);
        check($sformatf("%s:sum", tag), 32'(sum_o[i]), 32'(e[7:0]));
        check($sformatf("%s:cout", tag), 32'(cout_o[i]), 32'(e[8]));
        check($sformatf("%s:ovf", tag), 32'(ovf_o[i]), 32'(e[9]));
        check($sformatf("%s:dig_idle", tag), 32'({dig_valid[i], get_dig(i)}), 0);
        for (int h = 0; h < hold; h++) begin
            in_valid[i] = 1'b1;
            tick();
            check($sformatf("%s:hold_valid%0d", tag, h), 32'(res_valid[i]), 1);
            check($sformatf("%s:hold_in_ready%0d", tag, h), 32'(in_ready[i]), 0);
            check($sformatf("%s:hold_out%0d", tag, h),
                  32'({ovf_o[i], cout_o[i], sum_o[i]}), 32'(e));
        end
        in_valid[i]  = 1'b0;
        res_ready[i] = 1'b1;
        tick();
        res_ready[i] = 1'b0;
        check($sformatf("%s:res_drop", tag), 32'(res_valid[i]), 0);
        check($sformatf("%s:in_ready_back", tag), 32'(in_ready[i]), 1);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = '0; res_ready = '0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst%0d:in_ready", i), 32'(in_ready[i]), 1);
            check($sformatf("rst%0d:flags", i),
                  32'({res_valid[i], dig_valid[i], cout_o[i], ovf_o[i]}), 0);
            check($sformatf("rst%0d:sum", i), 32'(sum_o[i]), 0);
            check($sformatf("rst%0d:dig_sum", i), 32'(get_dig(i)), 0);
        end

        do_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 0, 1'b0, "t1");
        do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1, 1'b0, "t2");
        do_op(1, 8'h10, 8'h20, 1'b0, 1'b1, 0, 1'b0, "t3");
        do_op(2, 8'h7F, 8'h00, 1'b1, 1'b0, 5, 1'b0, "t4");

        a = 8'h33; b = 8'h44; cin = 1'b0; sub = 1'b0;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5:in_ready", 32'(in_ready[0]), 1);
        check("t5:res_valid", 32'(res_valid[0]), 0);
        check("t5:dig_valid", 32'(dig_valid[0]), 0);
        check("t5:outs", 32'({ovf_o[0], cout_o[0], sum_o[0]}), 0);
        do_op(0, 8'h81, 8'h7E, 1'b1, 1'b1, 2, 1'b0, "t5_after");

        for (int r = 0; r < 36; r++) begin
            do_op(r % 3, 8'($urandom), 8'($urandom), 1'((r / 3) % 2), 1'((r / 6) % 2),
                  int'($urandom_range(0, 3)), 1'b1, $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
